// File: rtl/matrix_axi_slave_mem_if.sv
// AXI4 slave bus bundle for matrix_axi_slave_mem: five channels, with master and slave views.
interface matrix_axi_slave_mem_if #(
  parameter int ID_W   = 1,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic [ID_W-1:0]     S_AXI_AWID;
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [7:0]          S_AXI_AWLEN;
  logic [2:0]          S_AXI_AWSIZE;
  logic [1:0]          S_AXI_AWBURST;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;

  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WLAST;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;

  logic [ID_W-1:0]     S_AXI_BID;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;

  logic [ID_W-1:0]     S_AXI_ARID;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [7:0]          S_AXI_ARLEN;
  logic [2:0]          S_AXI_ARSIZE;
  logic [1:0]          S_AXI_ARBURST;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;

  logic [ID_W-1:0]     S_AXI_RID;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RLAST;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/matrix_axi_slave_mem.sv
// AXI4 slave backed by a word-addressed RAM; independent write and read FSMs,
// one outstanding burst each, INCR/FIXED bursts only, full-width transfers.
module matrix_axi_slave_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  matrix_axi_slave_mem_if.slave s_axi
);
  localparam int WA_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << WA_W;
  localparam int LANES = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Word address wraps modulo the memory depth through the natural width overflow.
  function automatic logic [WA_W-1:0] next_addr(input logic [WA_W-1:0] a, input logic [1:0] burst);
    return (burst == BURST_INCR) ? a + 1'b1 : a;
  endfunction

  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

  // Size fields and byte offset are ignored: every beat is a full word.
  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWSIZE, s_axi.S_AXI_ARSIZE,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  // Holds both ready outputs low for the first cycle after reset release.
  logic run_q;
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  // ---------------- write path ----------------
  w_state_e                    w_state_q, w_state_d;
  logic [C_S_AXI_ID_WIDTH-1:0] awid_q;
  logic [WA_W-1:0]             waddr_q;
  logic [7:0]                  awlen_q, wbeat_q;
  logic [1:0]                  wburst_q;
  logic                        wbad_q, werr_q;
  logic                        aw_hs, w_hs, w_final;

  assign w_final = (wbeat_q == awlen_q);
  assign aw_hs   = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs    = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;

  // NOTE: every output is defaulted before the case so no latch is inferred.
  always_comb begin
    w_state_d            = w_state_q;
    s_axi.S_AXI_AWREADY  = 1'b0;
    s_axi.S_AXI_WREADY   = 1'b0;
    s_axi.S_AXI_BVALID   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        s_axi.S_AXI_AWREADY = run_q;
        if (run_q && s_axi.S_AXI_AWVALID) w_state_d = W_DATA;
      end
      W_DATA: begin
        s_axi.S_AXI_WREADY = 1'b1;
        if (s_axi.S_AXI_WVALID && w_final) w_state_d = W_RESP;
      end
      W_RESP: begin
        s_axi.S_AXI_BVALID = 1'b1;
        if (s_axi.S_AXI_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      awid_q    <= '0;
      waddr_q   <= '0;
      awlen_q   <= '0;
      wburst_q  <= '0;
      wbeat_q   <= '0;
      wbad_q    <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        awid_q   <= s_axi.S_AXI_AWID;
        waddr_q  <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        awlen_q  <= s_axi.S_AXI_AWLEN;
        wburst_q <= s_axi.S_AXI_AWBURST;
        wbeat_q  <= '0;
        wbad_q   <= !burst_ok(s_axi.S_AXI_AWBURST);
        werr_q   <= 1'b0;
      end else if (w_hs) begin
        waddr_q <= next_addr(waddr_q, wburst_q);
        wbeat_q <= wbeat_q + 8'd1;
        if (s_axi.S_AXI_WLAST != w_final) werr_q <= 1'b1;
      end
    end
  end

  assign s_axi.S_AXI_BID   = awid_q;
  assign s_axi.S_AXI_BRESP = (w_state_q == W_RESP && (wbad_q || werr_q)) ? RESP_SLVERR : RESP_OKAY;

  // NOTE: the storage array has no reset; contents survive ARESETN by design.
  logic [C_S_AXI_DATA_WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge ACLK) begin
    if (w_hs && !wbad_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (s_axi.S_AXI_WSTRB[i]) mem_q[waddr_q][8*i +: 8] <= s_axi.S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_e                      r_state_q, r_state_d;
  logic [C_S_AXI_ID_WIDTH-1:0]   arid_q;
  logic [WA_W-1:0]               raddr_q;
  logic [7:0]                    arlen_q, rbeat_q;
  logic [1:0]                    rburst_q;
  logic                          rbad_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic                          ar_hs, r_hs, r_final;
  logic [WA_W-1:0]               ar_word;

  assign ar_word = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign r_final = (rbeat_q == arlen_q);
  assign ar_hs   = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
  assign r_hs    = s_axi.S_AXI_RVALID  && s_axi.S_AXI_RREADY;

  always_comb begin
    r_state_d           = r_state_q;
    s_axi.S_AXI_ARREADY = 1'b0;
    s_axi.S_AXI_RVALID  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s_axi.S_AXI_ARREADY = run_q;
        if (run_q && s_axi.S_AXI_ARVALID) r_state_d = R_DATA;
      end
      R_DATA: begin
        s_axi.S_AXI_RVALID = 1'b1;
        if (s_axi.S_AXI_RREADY && r_final) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // rdata_q is fetched one beat ahead, so a same-cycle write to that word is not seen.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state_q <= R_IDLE;
      arid_q    <= '0;
      raddr_q   <= '0;
      arlen_q   <= '0;
      rburst_q  <= '0;
      rbeat_q   <= '0;
      rbad_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        arid_q   <= s_axi.S_AXI_ARID;
        rdata_q  <= mem_q[ar_word];
        raddr_q  <= next_addr(ar_word, s_axi.S_AXI_ARBURST);
        arlen_q  <= s_axi.S_AXI_ARLEN;
        rburst_q <= s_axi.S_AXI_ARBURST;
        rbeat_q  <= '0;
        rbad_q   <= !burst_ok(s_axi.S_AXI_ARBURST);
      end else if (r_hs && !r_final) begin
        rdata_q <= mem_q[raddr_q];
        raddr_q <= next_addr(raddr_q, rburst_q);
        rbeat_q <= rbeat_q + 8'd1;
      end
    end
  end

  assign s_axi.S_AXI_RID   = arid_q;
  assign s_axi.S_AXI_RDATA = (r_state_q == R_DATA && !rbad_q) ? rdata_q : '0;
  assign s_axi.S_AXI_RRESP = (r_state_q == R_DATA && rbad_q) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.S_AXI_RLAST = (r_state_q == R_DATA) && r_final;
endmodule

// File: tb/tb_matrix_axi_slave_mem.sv
// Directed bench for matrix_axi_slave_mem: bursts, strobes, wrap, error bursts, stalls, reset abort.
module tb_matrix_axi_slave_mem;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_axi_slave_mem_if #(.ID_W(1), .DATA_W(32), .ADDR_W(10)) bus ();

  matrix_axi_slave_mem #(
    .C_S_AXI_ID_WIDTH  (1),
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(10)
  ) dut (
    .ACLK   (clk),
    .ARESETN(rst_n),
    .s_axi  (bus.slave)
  );

  localparam int LIM = 20;
  int total = 0;
  int bad   = 0;
  logic [31:0] wdat [8];
  logic [31:0] rdat [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input logic [9:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] strb, input int bad_last, input logic [1:0] exp_resp,
                             input string tag);
    int n;
    bus.S_AXI_AWID    = 1'b1;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWLEN   = len;
    bus.S_AXI_AWSIZE  = 3'b010;
    bus.S_AXI_AWBURST = burst;
    bus.S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < LIM) begin tick(); n++; end
    if (n == LIM) check({tag, "_awready"}, 32'(bus.S_AXI_AWREADY), 32'd1);
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.S_AXI_WDATA  = wdat[i];
      bus.S_AXI_WSTRB  = strb;
      bus.S_AXI_WLAST  = (i == int'(len)) ^ (i == bad_last);
      bus.S_AXI_WVALID = 1'b1;
      n = 0;
      while (!bus.S_AXI_WREADY && n < LIM) begin tick(); n++; end
      if (n == LIM) check({tag, "_wready"}, 32'(bus.S_AXI_WREADY), 32'd1);
      tick();
    end
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_WLAST  = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    n = 0;
    while (!bus.S_AXI_BVALID && n < LIM) begin tick(); n++; end
    check({tag, "_bvalid"}, 32'(bus.S_AXI_BVALID), 32'd1);
    check({tag, "_bresp"}, 32'(bus.S_AXI_BRESP), 32'(exp_resp));
    check({tag, "_bid"}, 32'(bus.S_AXI_BID), 32'd1);
    tick();
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic start_read(input logic [9:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input string tag);
    int n;
    bus.S_AXI_ARID    = 1'b1;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARLEN   = len;
    bus.S_AXI_ARSIZE  = 3'b000;
    bus.S_AXI_ARBURST = burst;
    bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < LIM) begin tick(); n++; end
    if (n == LIM) check({tag, "_arready"}, 32'(bus.S_AXI_ARREADY), 32'd1);
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    check({tag, "_rvalid_first"}, 32'(bus.S_AXI_RVALID), 32'd1);
  endtask

  task automatic read_burst(input logic [9:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [1:0] exp_resp, input string tag);
    int n;
    start_read(addr, len, burst, tag);
    bus.S_AXI_RREADY = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!bus.S_AXI_RVALID && n < LIM) begin tick(); n++; end
      check($sformatf("%s_rdata%0d", tag, i), bus.S_AXI_RDATA, rdat[i]);
      check($sformatf("%s_rlast%0d", tag, i), 32'(bus.S_AXI_RLAST), 32'(i == int'(len)));
      check($sformatf("%s_rresp%0d", tag, i), 32'(bus.S_AXI_RRESP), 32'(exp_resp));
      check($sformatf("%s_rid%0d", tag, i), 32'(bus.S_AXI_RID), 32'd1);
      tick();
    end
    bus.S_AXI_RREADY = 1'b0;
    check({tag, "_rvalid_end"}, 32'(bus.S_AXI_RVALID), 32'd0);
  endtask

  initial begin
    int beat;
    int n;
    bus.S_AXI_AWID = '0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWSIZE = '0;
    bus.S_AXI_AWBURST = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARID = '0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARSIZE = '0;
    bus.S_AXI_ARBURST = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_ctrl", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                           bus.S_AXI_ARREADY, bus.S_AXI_RVALID, bus.S_AXI_RLAST}), 32'd0);
    check("rst_resp", 32'({bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_BID, bus.S_AXI_RID}), 32'd0);
    check("rst_rdata", bus.S_AXI_RDATA, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_awready_pre", 32'(bus.S_AXI_AWREADY), 32'd0);
    tick();
    check("rel_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    check("rel_arready", 32'(bus.S_AXI_ARREADY), 32'd1);

    // INCR burst write and read back
    wdat[0] = 32'hA0; wdat[1] = 32'hA1; wdat[2] = 32'hA2; wdat[3] = 32'hA3;
    write_burst(10'h010, 8'd3, 2'b01, 4'hF, -1, 2'b00, "incr");
    rdat[0] = 32'hA0; rdat[1] = 32'hA1; rdat[2] = 32'hA2; rdat[3] = 32'hA3;
    read_burst(10'h010, 8'd3, 2'b01, 2'b00, "incr");

    // Address wrap at top of memory
    wdat[0] = 32'h11; wdat[1] = 32'h22;
    write_burst(10'h3FC, 8'd1, 2'b01, 4'hF, -1, 2'b00, "wrap");
    rdat[0] = 32'h11;
    read_burst(10'h3FC, 8'd0, 2'b01, 2'b00, "wrap_top");
    rdat[0] = 32'h22;
    read_burst(10'h000, 8'd0, 2'b01, 2'b00, "wrap_zero");

    // Byte strobes
    wdat[0] = 32'hFFFF_FFFF;
    write_burst(10'h020, 8'd0, 2'b01, 4'hF, -1, 2'b00, "strb_full");
    wdat[0] = 32'h1234_5678;
    write_burst(10'h020, 8'd0, 2'b01, 4'h5, -1, 2'b00, "strb_part");
    rdat[0] = 32'hFF34_FF78;
    read_burst(10'h020, 8'd0, 2'b01, 2'b00, "strb");

    // WRAP burst: no write, SLVERR on write and on every read beat
    wdat[0] = 32'hCAFE_F00D;
    write_burst(10'h040, 8'd0, 2'b01, 4'hF, -1, 2'b00, "pre40");
    wdat[0] = 32'h1111_1111; wdat[1] = 32'h2222_2222;
    write_burst(10'h040, 8'd1, 2'b10, 4'hF, -1, 2'b10, "wrapw");
    rdat[0] = 32'hCAFE_F00D;
    read_burst(10'h040, 8'd0, 2'b01, 2'b00, "wrapw_keep");
    rdat[0] = '0; rdat[1] = '0; rdat[2] = '0;
    read_burst(10'h040, 8'd2, 2'b10, 2'b10, "wrapr");

    // FIXED burst keeps the address: last beat wins
    wdat[0] = 32'h1; wdat[1] = 32'h2; wdat[2] = 32'h3;
    write_burst(10'h050, 8'd2, 2'b00, 4'hF, -1, 2'b00, "fixed");
    rdat[0] = 32'h3;
    read_burst(10'h050, 8'd0, 2'b01, 2'b00, "fixed");

    // WLAST misplaced: SLVERR but data written; count governs burst length
    wdat[0] = 32'h3000_0000; wdat[1] = 32'h3000_0001;
    write_burst(10'h030, 8'd1, 2'b01, 4'hF, 0, 2'b10, "early_last");
    rdat[0] = 32'h3000_0000; rdat[1] = 32'h3000_0001;
    read_burst(10'h030, 8'd1, 2'b01, 2'b00, "early_last");
    wdat[0] = 32'h3800_0000;
    write_burst(10'h038, 8'd0, 2'b01, 4'hF, 0, 2'b10, "missing_last");

    // 8-beat read with RREADY toggling
    for (int i = 0; i < 8; i++) begin
      wdat[i] = 32'hB000_0000 + 32'(i);
      rdat[i] = 32'hB000_0000 + 32'(i);
    end
    write_burst(10'h080, 8'd7, 2'b01, 4'hF, -1, 2'b00, "stall_fill");
    start_read(10'h080, 8'd7, 2'b01, "stall");
    beat = 0;
    for (int c = 0; c < 40 && beat < 8; c++) begin
      bus.S_AXI_RREADY = c[0];
      #1;
      if (bus.S_AXI_RVALID) begin
        check($sformatf("stall_rdata%0d_c%0d", beat, c), bus.S_AXI_RDATA, rdat[beat]);
        check($sformatf("stall_rlast%0d_c%0d", beat, c), 32'(bus.S_AXI_RLAST), 32'(beat == 7));
        if (bus.S_AXI_RREADY) beat++;
      end
      tick();
    end
    bus.S_AXI_RREADY = 1'b0;
    check("stall_beats", 32'(beat), 32'd8);
    check("stall_rvalid_end", 32'(bus.S_AXI_RVALID), 32'd0);

    // Read fetched in the same cycle as a write to that word sees old data
    wdat[0] = 32'h55;
    write_burst(10'h070, 8'd0, 2'b01, 4'hF, -1, 2'b00, "rbw_pre");
    bus.S_AXI_AWADDR = 10'h070; bus.S_AXI_AWLEN = 8'd0; bus.S_AXI_AWBURST = 2'b01;
    bus.S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < LIM) begin tick(); n++; end
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = 32'h66; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WLAST = 1'b1; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARADDR = 10'h070; bus.S_AXI_ARLEN = 8'd0; bus.S_AXI_ARBURST = 2'b01;
    bus.S_AXI_ARVALID = 1'b1;
    check("rbw_both_ready", 32'({bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 32'b11);
    tick();
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    check("rbw_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
    check("rbw_old_data", bus.S_AXI_RDATA, 32'h55);
    check("rbw_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    bus.S_AXI_RREADY = 1'b1; bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
    rdat[0] = 32'h66;
    read_burst(10'h070, 8'd0, 2'b01, 2'b00, "rbw_new");

    // Simultaneous AW and AR handshakes
    bus.S_AXI_AWADDR = 10'h074; bus.S_AXI_AWLEN = 8'd0; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_ARADDR = 10'h010; bus.S_AXI_ARLEN = 8'd0; bus.S_AXI_ARVALID = 1'b1;
    check("dual_ready", 32'({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}), 32'b11);
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    check("dual_accepted", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_RVALID}),
          32'b0101);
    check("dual_rdata", bus.S_AXI_RDATA, 32'hA0);
    bus.S_AXI_RREADY = 1'b1;
    bus.S_AXI_WDATA = 32'h77; bus.S_AXI_WLAST = 1'b1; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
    check("dual_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;

    // Reset during beat 2 of a 4-beat write
    wdat[0] = 32'h0BAD_BEEF;
    write_burst(10'h0C8, 8'd0, 2'b01, 4'hF, -1, 2'b00, "abort_pre");
    bus.S_AXI_AWADDR = 10'h0C0; bus.S_AXI_AWLEN = 8'd3; bus.S_AXI_AWBURST = 2'b01;
    bus.S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < LIM) begin tick(); n++; end
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.S_AXI_WDATA = 32'hC0C0_0000 + 32'(i); bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b1;
      tick();
    end
    bus.S_AXI_WDATA = 32'hC0C0_0002;
    rst_n = 1'b0;
    #1;
    check("abort_in_reset", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID}), 32'd0);
    tick();
    tick();
    bus.S_AXI_WVALID = 1'b0;
    rst_n = 1'b1;
    tick();
    check("abort_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.S_AXI_BVALID) n++;
      tick();
    end
    check("abort_no_bvalid", 32'(n), 32'd0);
    rdat[0] = 32'hC0C0_0000; rdat[1] = 32'hC0C0_0001; rdat[2] = 32'h0BAD_BEEF;
    read_burst(10'h0C0, 8'd2, 2'b01, 2'b00, "abort_keep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
